eq_serial_cmp: RTL and testbench



---
 rtl/eq_serial_cmp.sv | 149 ++++++++++++++
 tb/tb_eq_serial_cmp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_serial_cmp.sv
// eq_serial_cmp: sequential N-bit equality checker.
// Latches two operands on an accepted start, compares them LSB-first one bit
// per clock with a 1-bit equality stage, then reports eq / mis_cnt together
// with a one-cycle done_tick.
// Optional build macro EQ_SERIAL_EARLY_EXIT_EN: when defined, the first
// mismatching bit ends the scan early (eq=0, mis_cnt=1).
module eq_serial_cmp #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         eq,
  output logic [W-1:0] mis_cnt
);

  // Bit index counter only needs to reach N-1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   sh_a_q;
  logic [N-1:0]   sh_b_q;
  logic [CW-1:0]  bit_cnt_q;
  logic           run_eq_q;
  logic [W-1:0]   run_cnt_q;
  logic           eq_q;
  logic [W-1:0]   mis_cnt_q;

  logic           e_bit;
  logic           run_eq_nxt;
  logic [W-1:0]   run_cnt_nxt;

  // 1-bit equality stage: equal when both bits are 0 or both are 1.
  function automatic logic bit_eq(input logic x, input logic y);
    logic p0;
    logic p1;
    p0 = ~x & ~y;
    p1 = x & y;
    return p0 | p1;
  endfunction

  // Mismatch accumulator; the count is bounded by N, which W always holds.
  function automatic logic [W-1:0] add_mis(input logic [W-1:0] cnt, input logic e);
    return cnt + W'(~e);
  endfunction

  assign e_bit       = bit_eq(sh_a_q[0], sh_b_q[0]);
  assign run_eq_nxt  = run_eq_q & e_bit;
  assign run_cnt_nxt = add_mis(run_cnt_q, e_bit);

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign eq        = eq_q;
  assign mis_cnt   = mis_cnt_q;

  // State register; reset abandons any comparison in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: scan all bits (or stop at the first mismatch when early exit is built in).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CMP;
        end
      end
      CMP: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
`ifdef EQ_SERIAL_EARLY_EXIT_EN
        else if (!e_bit) begin
          state_d = DONE;
        end
`else
        else begin
          state_d = CMP;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand shift registers, running accumulators and the registered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      bit_cnt_q <= '0;
      run_eq_q  <= 1'b1;
      run_cnt_q <= '0;
      eq_q      <= 1'b0;
      mis_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sh_a_q    <= a;
            sh_b_q    <= b;
            bit_cnt_q <= '0;
            run_eq_q  <= 1'b1;
            run_cnt_q <= '0;
          end
        end
        CMP: begin
          run_eq_q  <= run_eq_nxt;
          run_cnt_q <= run_cnt_nxt;
          sh_a_q    <= sh_a_q >> 1;
          sh_b_q    <= sh_b_q >> 1;
          bit_cnt_q <= bit_cnt_q + CW'(1);
          // Publish the final accumulator values on the edge that enters DONE.
          if (state_d == DONE) begin
            eq_q      <= run_eq_nxt;
            mis_cnt_q <= run_cnt_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_serial_cmp.sv
// Directed bench for eq_serial_cmp (N=8 instance plus an N=1 instance).
// Expected values track the EQ_SERIAL_EARLY_EXIT_EN build macro.
module tb_eq_serial_cmp;

`ifdef EQ_SERIAL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;
  logic       done_tick;
  logic       eq;
  logic [3:0] mis_cnt;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       ready1;
  logic       done1;
  logic       eq1;
  logic [0:0] mis1;

  int n_chk;
  int n_fail;

  eq_serial_cmp #(.N(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done_tick(done_tick),
    .eq       (eq),
    .mis_cnt  (mis_cnt)
  );

  eq_serial_cmp #(.N(1)) dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start1),
    .a        (a1),
    .b        (b1),
    .ready    (ready1),
    .done_tick(done1),
    .eq       (eq1),
    .mis_cnt  (mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input bit scr, input int exp_lat, input logic exp_eq,
                        input logic [3:0] exp_cnt);
    int lat;
    int guard;
    guard = 0;
    while (!ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_ready_before"}, 32'(ready), 32'd1);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, 32'(ready), 32'd0);
    while (!done_tick && lat < 40) begin
      if (scr) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_eq"}, 32'(eq), 32'(exp_eq));
    chk({tag, "_mis_cnt"}, 32'(mis_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    chk({tag, "_tick_width"}, 32'(done_tick), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  task automatic do_cmp1(input string tag, input logic av, input logic bv,
                         input logic exp_eq, input logic exp_cnt);
    int lat;
    @(negedge clk);
    a1 = av;
    b1 = bv;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_eq"}, 32'(eq1), 32'(exp_eq));
    chk({tag, "_mis_cnt"}, 32'(mis1), 32'(exp_cnt));
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, 32'(ready1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nd;
    int d1;
    int d2;
    int lat_b;
    logic eq_b;
    logic [3:0] cnt_b;

    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    start1  = 1'b0;
    a1      = '0;
    b1      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done_tick), 32'd0);
    chk("rst_eq", 32'(eq), 32'd0);
    chk("rst_mis_cnt", 32'(mis_cnt), 32'd0);

    // Equal operands always scan the full width.
    do_cmp("eq_5a", 8'h5A, 8'h5A, 1'b0, 9, 1'b1, 4'd0);
    // All bits differ; early exit stops at bit 0.
    do_cmp("mis_f0", 8'hF0, 8'h0F, 1'b0, EE ? 2 : 9, 1'b0, EE ? 4'd1 : 4'd8);
    do_cmp("mis_a5", 8'hA5, 8'hA4, 1'b0, EE ? 2 : 9, 1'b0, 4'd1);
    do_cmp("mis_f0b", 8'hF0, 8'h0F, 1'b0, EE ? 2 : 9, 1'b0, EE ? 4'd1 : 4'd8);

    // Asynchronous reset in the middle of CMP (first mismatch at bit 4).
    @(negedge clk);
    a = 8'hF0;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done_tick), 32'd0);
    chk("midrst_eq", 32'(eq), 32'd0);
    chk("midrst_mis_cnt", 32'(mis_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_cmp("post_rst_3c", 8'h3C, 8'h3C, 1'b0, 9, 1'b1, 4'd0);

    // First mismatch at bit 2.
    do_cmp("early_04", 8'h04, 8'h00, 1'b0, EE ? 4 : 9, 1'b0, 4'd1);

    // Operands scrambled every cycle after acceptance.
    do_cmp("stable_c3", 8'hC3, 8'hC3, 1'b1, 9, 1'b1, 4'd0);

    // Busy start ignored: 33 vs 31 differ only at bit 1.
    @(negedge clk);
    a = 8'h33;
    b = 8'h31;
    start = 1'b1;
    nd = 0;
    lat_b = 0;
    eq_b = 1'b1;
    cnt_b = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start = 1'b0;
      end
      if (i == 2) begin
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
      end
      if (i == 3) begin
        start = 1'b0;
      end
      if (done_tick) begin
        nd++;
        if (nd == 1) begin
          lat_b = i;
          eq_b = eq;
          cnt_b = mis_cnt;
        end
      end
    end
    chk("busy_done_count", 32'(nd), 32'd1);
    chk("busy_latency", 32'(lat_b), EE ? 32'd3 : 32'd9);
    chk("busy_eq", 32'(eq_b), 32'd0);
    chk("busy_mis_cnt", 32'(cnt_b), 32'd1);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'h11;
    b = 8'h11;
    start = 1'b1;
    nd = 0;
    d1 = -1;
    d2 = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        b = 8'h13;
      end
      if (done_tick) begin
        nd++;
        if (nd == 1) begin
          d1 = i;
          chk("b2b_first_eq", 32'(eq), 32'd1);
          chk("b2b_first_mis_cnt", 32'(mis_cnt), 32'd0);
        end else if (nd == 2) begin
          d2 = i;
          start = 1'b0;
          chk("b2b_second_eq", 32'(eq), 32'd0);
          chk("b2b_second_mis_cnt", 32'(mis_cnt), 32'd1);
        end
      end
    end
    chk("b2b_done_count", 32'(nd), 32'd2);
    chk("b2b_first_latency", 32'(d1), 32'd9);
    chk("b2b_spacing", 32'(d2 - d1), EE ? 32'd4 : 32'd10);

    // Single-bit instance.
    chk("n1_ready_idle", 32'(ready1), 32'd1);
    do_cmp1("n1_diff", 1'b1, 1'b0, 1'b0, 1'b1);
    do_cmp1("n1_same", 1'b1, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
